instr_mem_sync: RTL and testbench

//  Synchronous, parametrised instruction memory for the pipelined MIPS core.
//  A streaming load port fills the memory after reset; no simulation file I/O is used.

---
 rtl/instr_mem_sync.sv | 125 ++++++++++++
 tb/tb_instr_mem_sync.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory: a streaming load port fills the array, then a
// valid/ready fetch port returns one registered word per request.
module instr_mem_sync #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter logic [31:0] NOP    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        loaded,
  input  logic        reload,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err
);

  localparam int unsigned HI_LSB = ADDR_W + 2;

  typedef enum logic {S_LOAD, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   load_ptr_q, load_ptr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_instr_q, rsp_instr_d;
  logic                rsp_err_q, rsp_err_d;
  logic [31:0]         mem_q [DEPTH];

  logic                in_run;
  logic                out_free;
  logic                reload_go;
  logic                load_fire;
  logic                load_end;
  logic                req_fire;
  logic                addr_ok;
  logic [ADDR_W-1:0]   word_idx;

  // Handshake qualifiers and fetch address decode
  always_comb begin
    in_run    = (state_q == S_RUN);
    out_free  = !rsp_valid_q || rsp_ready;
    reload_go = in_run && reload && out_free;
    load_fire = !in_run && load_valid;
    load_end  = load_last || (load_ptr_q == ADDR_W'(DEPTH - 1));
    req_fire  = req_valid && req_ready;
    word_idx  = req_addr[HI_LSB-1:2];
    addr_ok   = (req_addr[1:0] == 2'b00) && (req_addr[31:HI_LSB] == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (load_fire && load_end) state_d = S_RUN;
      S_RUN:   if (reload_go) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // A pending reload blocks new fetches so the output register can empty
  always_comb begin
    load_ready = !in_run;
    loaded     = in_run;
    req_ready  = in_run && out_free && !reload;
  end

  always_comb begin
    load_ptr_d  = load_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_err_d   = rsp_err_q;
    if (reload_go) begin
      load_ptr_d = '0;
    end else if (load_fire && (load_ptr_q != ADDR_W'(DEPTH - 1))) begin
      load_ptr_d = load_ptr_q + ADDR_W'(1);
    end
    if (req_fire) begin
      rsp_valid_d = 1'b1;
      rsp_instr_d = addr_ok ? mem_q[word_idx] : NOP;
      rsp_err_d   = !addr_ok;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_ptr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      load_ptr_q  <= load_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array contents survive reset so a partial load keeps its words
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_q[load_ptr_q] <= load_data;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: table-driven fetches checked through a response
// scoreboard, plus directed load/reload/reset sequences.
module tb_instr_mem_sync;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 8;

  localparam logic [31:0] A0 = 32'h2008_0001;
  localparam logic [31:0] A1 = 32'h2009_0002;
  localparam logic [31:0] A2 = 32'h012A_5820;
  localparam logic [31:0] A3 = 32'hAC0B_0010;
  localparam logic [31:0] B0 = 32'h3C01_BEEF;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        loaded;
  logic        reload;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  rsp_t        exp_q[$];
  vec_t        tbl1[9];
  vec_t        tbl2[7];
  logic [31:0] model_mem [DEPTH];
  int unsigned model_ptr;
  int          n_checks = 0;
  int          n_pass   = 0;

  instr_mem_sync #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .loaded     (loaded),
    .reload     (reload),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_instr  (rsp_instr),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fill_word(input int unsigned i);
    return 32'h5A00_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: every response handshake pops the oldest expected entry
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin : pop
      rsp_t e;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got %h expected no response", rsp_instr);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_instr", rsp_instr, e.instr);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    #1;
    chk("load_ready_beat", 32'(load_ready), 32'd1);
    model_mem[model_ptr] = d;
    if (model_ptr < DEPTH - 1) model_ptr++;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] ei, input logic ee);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    #1;
    while (!req_ready && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL req_accept: got timeout expected accept of %h", a);
    end else begin
      exp_q.push_back('{instr: ei, err: ee});
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic issue_m(input logic [31:0] a);
    logic bad;
    bad = (a % 4 != 0) || (a >= 32'(4 * DEPTH));
    if (bad) issue(a, 32'h0, 1'b1);
    else     issue(a, model_mem[a[ADDR_W+1:2]], 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl1[0] = '{addr: 32'h0000_0000, instr: A0,    err: 1'b0};
    tbl1[1] = '{addr: 32'h0000_0004, instr: A1,    err: 1'b0};
    tbl1[2] = '{addr: 32'h0000_0008, instr: A2,    err: 1'b0};
    tbl1[3] = '{addr: 32'h0000_000C, instr: A3,    err: 1'b0};
    tbl1[4] = '{addr: 32'h0000_0002, instr: 32'h0, err: 1'b1};
    tbl1[5] = '{addr: 32'h0000_0400, instr: 32'h0, err: 1'b1};
    tbl1[6] = '{addr: 32'hFFFF_FFFC, instr: 32'h0, err: 1'b1};
    tbl1[7] = '{addr: 32'h0000_0001, instr: 32'h0, err: 1'b1};
    tbl1[8] = '{addr: 32'h0000_0004, instr: A1,    err: 1'b0};

    tbl2[0] = '{addr: 32'h0000_03FC, instr: fill_word(DEPTH - 1), err: 1'b0};
    tbl2[1] = '{addr: 32'h0000_0000, instr: fill_word(0),         err: 1'b0};
    tbl2[2] = '{addr: 32'h0000_0200, instr: fill_word(128),       err: 1'b0};
    tbl2[3] = '{addr: 32'h0000_0400, instr: 32'h0,                err: 1'b1};
    tbl2[4] = '{addr: 32'h0000_03FE, instr: 32'h0,                err: 1'b1};
    tbl2[5] = '{addr: 32'h0001_0000, instr: 32'h0,                err: 1'b1};
    tbl2[6] = '{addr: 32'h0000_0004, instr: fill_word(1),         err: 1'b0};

    reset = 1'b1;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0; reload = 1'b0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    model_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_instr", rsp_instr, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // Short load ending on load_last
    load_beat(A0, 1'b0);
    load_beat(A1, 1'b0);
    load_beat(A2, 1'b0);
    load_beat(A3, 1'b1);
    chk("loaded_after_last", 32'(loaded), 32'd1);
    chk("load_ready_run", 32'(load_ready), 32'd0);

    // Back-to-back table fetches: each response visible one cycle after its request
    rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue(tbl1[i].addr, tbl1[i].instr, tbl1[i].err);
      chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t1_rsp_instr_now", rsp_instr, tbl1[i].instr);
    end
    drain();
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

    // Backpressure: response held stable, new request stalled until release
    rsp_ready = 1'b0;
    issue(32'h4, A1, 1'b0);
    req_valid = 1'b1;
    req_addr  = 32'h8;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_instr", rsp_instr, A1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("release_req_ready", 32'(req_ready), 32'd1);
    exp_q.push_back('{instr: A2, err: 1'b0});
    step();
    req_valid = 1'b0;
    chk("release_rsp_instr", rsp_instr, A2);
    drain();

    // Reload, then fill every word without load_last
    reload = 1'b1;
    #1;
    chk("reload_req_ready", 32'(req_ready), 32'd0);
    step();
    reload = 1'b0;
    chk("reload_loaded", 32'(loaded), 32'd0);
    chk("reload_load_ready", 32'(load_ready), 32'd1);
    model_ptr = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i == int'(DEPTH) - 1) chk("before_final_loaded", 32'(loaded), 32'd0);
      load_beat(fill_word(i), 1'b0);
    end
    chk("auto_run_loaded", 32'(loaded), 32'd1);

    // Load beats in RUN must not touch memory
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    #1;
    chk("run_load_ready", 32'(load_ready), 32'd0);
    step();
    load_valid = 1'b0;

    for (int i = 0; i < 7; i++) begin
      issue(tbl2[i].addr, tbl2[i].instr, tbl2[i].err);
    end
    drain();

    // Reset with a response in flight
    rsp_ready = 1'b0;
    issue_m(32'h10);
    #3;
    reset = 1'b1;
    #1;
    chk("midfetch_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midfetch_rsp_instr", rsp_instr, 32'h0);
    chk("midfetch_loaded", 32'(loaded), 32'd0);
    exp_q.delete();
    model_ptr = 0;
    step();
    reset = 1'b0;
    rsp_ready = 1'b1;

    // Reset mid-load keeps the partial words and restarts at index 0
    load_beat(A0, 1'b0);
    load_beat(A1, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("midload_load_ready", 32'(load_ready), 32'd1);
    model_ptr = 0;
    step();
    reset = 1'b0;
    load_beat(B0, 1'b1);
    chk("reload_done_loaded", 32'(loaded), 32'd1);
    issue(32'h0, B0, 1'b0);
    issue(32'h4, A1, 1'b0);
    issue_m(32'h8);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
